spi_bus_arbiter: RTL
====================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Parameters
REQ-001 SHALL have NumReq, default 4, meaning the number of requesters sharing one SPI engine (range 2..8).
REQ-002 SHALL have CsSetupCycles, default 2, meaning the clock cycles between chip-select assertion and grant (range 1..15).
REQ-003 SHALL have CsHoldCycles, default 2, meaning the clock cycles between release and chip-select deassertion (range 1..15).

Interface
REQ-004 SHALL have clk_sys_i, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 SHALL have rst_sys_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have req_i, input, NumReq bits: per-requester bus request, held for the whole transaction.
REQ-007 SHALL have gnt_o, output, NumReq bits: one-hot grant, or all zero.
REQ-008 SHALL have tx_valid_i, input, NumReq bits: per-requester transmit byte valid.
REQ-009 SHALL have tx_data_i, input, NumReq*8 bits: per-requester transmit byte; requester n uses bits [8n+7:8n].
REQ-010 SHALL have tx_ready_o, output, NumReq bits: per-requester transmit byte accepted.
REQ-011 SHALL have rx_valid_o, output, NumReq bits: per-requester receive byte strobe.
REQ-012 SHALL have rx_data_o, output, 8 bits: shared receive byte.
REQ-013 SHALL have eng_tx_valid_o, output, 1 bit: transmit byte valid to the SPI engine.
REQ-014 SHALL have eng_tx_data_o, output, 8 bits: transmit byte to the SPI engine.
REQ-015 SHALL have eng_tx_ready_i, input, 1 bit: SPI engine accepts the transmit byte.
REQ-016 SHALL have eng_rx_valid_i, input, 1 bit: SPI engine receive byte strobe.
REQ-017 SHALL have eng_rx_data_i, input, 8 bits: SPI engine receive byte.
REQ-018 SHALL have eng_busy_i, input, 1 bit: SPI engine is shifting or holds an unreturned byte.
REQ-019 SHALL have cs_no, output, NumReq bits: per-target chip select, active-low.

Function
REQ-020 SHALL implement four states:
- IDLE
- SETUP
- ACTIVE
- HOLD
REQ-021 IDLE: when any req_i bit is set, SHALL select a winner by round-robin, searching from index (last_winner+1) mod NumReq upward with wrap-around.
- In the same cycle as the selection, SHALL latch the winner, update last_winner, and go to SETUP.
REQ-022 SETUP: SHALL drive cs_no[winner]=0 and count CsSetupCycles cycles, then go to ACTIVE.
REQ-023 ACTIVE: SHALL set gnt_o[winner]=1, keep cs_no[winner]=0, and connect the datapath as follows:
- eng_tx_valid_o = tx_valid_i[winner]
- eng_tx_data_o = winner's byte
- tx_ready_o[winner] = eng_tx_ready_i
- rx_valid_o[winner] = eng_rx_valid_i
- All other tx_ready_o and rx_valid_o bits SHALL be 0.
REQ-024 ACTIVE exit SHALL occur when req_i[winner]=0 and eng_busy_i=0 in the same cycle, then go to HOLD.
- If req_i drops while eng_busy_i=1, SHALL stay in ACTIVE, forwarding rx only, with eng_tx_valid_o forced 0.
REQ-025 HOLD: SHALL drive gnt_o=0 and eng_tx_valid_o=0, keep cs_no[winner]=0 for CsHoldCycles cycles, then drive cs_no to all ones and go to IDLE.
- Latency from req_i to gnt_o is at least 1+CsSetupCycles cycles.
REQ-026 At most one cs_no bit SHALL be low at any time.
- cs_no SHALL be all ones in IDLE.
- At least one cycle of all ones SHALL separate consecutive transactions.
REQ-027 Requests arriving during SETUP, ACTIVE or HOLD SHALL NOT pre-empt the owner; they are evaluated at the next IDLE.
REQ-028 If req_i[winner] drops during SETUP, SHALL still complete SETUP, then pass through ACTIVE (1 cycle, if eng_busy_i=0) and HOLD normally.
REQ-029 rx_data_o SHALL equal eng_rx_data_i combinationally.
- gnt_o, cs_no and the state SHALL be registered.
- The setup/hold counter SHALL be 4 bits and saturate-free, loaded on state entry.

Reset
REQ-030 On rst_sys_ni=0, asynchronously: state=IDLE, gnt_o=0, cs_no=all ones, counter=0, last_winner=NumReq-1 (first search starts at index 0).
REQ-031 All combinational outputs SHALL evaluate to 0 in IDLE after reset: tx_ready_o, rx_valid_o, eng_tx_valid_o.
REQ-032 Reset asserted mid-transaction SHALL deassert cs_no immediately, with no HOLD phase.

Verification
REQ-033 Single request: req_i=4'b0100 at cycle 0, defaults -> cs_no=4'b1011 from cycle 1; gnt_o=4'b0100 from cycle 3; two bytes 0xA5, 0x3C appear on eng_tx_data_o with handshakes.
REQ-034 Round-robin: req_i=4'b1111 held, each owner releases after 1 byte -> grant order 0,1,2,3,0; cs_no never has two zeros; one all-ones cycle between owners.
REQ-035 Release while busy: owner drops req_i with eng_busy_i=1 for 5 cycles -> ACTIVE held 5 cycles; a final eng_rx_valid_i strobe is routed to rx_valid_o[owner]; HOLD starts after eng_busy_i=0.
REQ-036 Wrap-around: last_winner=3, req_i=4'b0011 -> requester 0 wins; next arbitration -> requester 1.
REQ-037 Reset mid-ACTIVE: assert rst_sys_ni=0 while gnt_o=4'b0010 -> gnt_o=0 and cs_no=4'b1111 in the same cycle; first grant after reset goes to the lowest requesting index.
REQ-038 Non-owner isolation: requester 2 drives tx_valid_i while requester 1 owns -> tx_ready_o[2]=0, and requester 2's byte never appears on eng_tx_data_o.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share a single SPI engine.
// Each transaction is framed by chip-select setup and hold phases around the grant.
module spi_bus_arbiter #(
  parameter int NumReq        = 4,
  parameter int CsSetupCycles = 2,
  parameter int CsHoldCycles  = 2
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_ni,
  input  logic [NumReq-1:0]     req_i,
  output logic [NumReq-1:0]     gnt_o,
  input  logic [NumReq-1:0]     tx_valid_i,
  input  logic [NumReq*8-1:0]   tx_data_i,
  output logic [NumReq-1:0]     tx_ready_o,
  output logic [NumReq-1:0]     rx_valid_o,
  output logic [7:0]            rx_data_o,
  output logic                  eng_tx_valid_o,
  output logic [7:0]            eng_tx_data_o,
  input  logic                  eng_tx_ready_i,
  input  logic                  eng_rx_valid_i,
  input  logic [7:0]            eng_rx_data_i,
  input  logic                  eng_busy_i,
  output logic [NumReq-1:0]     cs_no
);

  localparam int IdxW = $clog2(NumReq);
  localparam logic [NumReq-1:0] OneHot0 = {{(NumReq-1){1'b0}}, 1'b1};

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   cand_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StActive,
    StHold
  } state_e;

  state_e                state_q;
  idx_t                  last_q;
  idx_t                  pick_d;
  cand_t                 cand;
  logic [3:0]            cnt_q;
  logic [NumReq-1:0]     gnt_q;
  logic [NumReq-1:0]     cs_n_q;
  logic                  owner_req;
  logic [7:0]            tx_byte;

  // Round-robin search starting just after the previous winner, wrapping once.
  always_comb begin
    pick_d = last_q;
    cand   = '0;
    for (int k = NumReq; k >= 1; k--) begin
      cand = {1'b0, last_q} + cand_t'(k);
      if (cand >= cand_t'(NumReq)) begin
        cand = cand - cand_t'(NumReq);
      end
      if (req_i[cand[IdxW-1:0]]) begin
        pick_d = cand[IdxW-1:0];
      end
    end
  end

  // last_q doubles as the current owner from SETUP through HOLD.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= StIdle;
      last_q  <= idx_t'(NumReq - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      cs_n_q  <= '1;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req_i) begin
            last_q  <= pick_d;
            cs_n_q  <= ~(OneHot0 << pick_d);
            cnt_q   <= 4'(CsSetupCycles - 1);
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == 4'd0) begin
            gnt_q   <= OneHot0 << last_q;
            state_q <= StActive;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StActive: begin
          if (!owner_req && !eng_busy_i) begin
            gnt_q   <= '0;
            cnt_q   <= 4'(CsHoldCycles - 1);
            state_q <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == 4'd0) begin
            cs_n_q  <= '1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // gnt_q is non-zero only in ACTIVE, so it also serves as the datapath select.
  assign owner_req = |(req_i & gnt_q);

  always_comb begin
    tx_byte = '0;
    for (int n = 0; n < NumReq; n++) begin
      tx_byte = tx_byte | (tx_data_i[8*n +: 8] & {8{gnt_q[n]}});
    end
  end

  assign eng_tx_valid_o = owner_req & (|(tx_valid_i & gnt_q));
  assign eng_tx_data_o  = tx_byte;
  assign tx_ready_o     = (owner_req && eng_tx_ready_i) ? gnt_q : '0;
  assign rx_valid_o     = eng_rx_valid_i ? gnt_q : '0;
  assign rx_data_o      = eng_rx_data_i;
  assign gnt_o          = gnt_q;
  assign cs_no          = cs_n_q;

endmodule
